alu_sched: RTL

- Shares the 16-bit ALU between NREQ requesters using round-robin arbitration.
- Sequences multi-cycle iterated operations on the shared ALU, e.g. SHL by N or repeated ADD (A + N·B).
- Drives the ALU's A/B/select inputs and samples its result and carry.
- Returns each result with the requester ID over a valid/ready response channel.

---
 rtl/alu_sched.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one 16-bit ALU between NREQ requesters, iterating each op rep+1 times.
// Define ALU_SCHED_PERF_EN to add the perf_ops completed-response counter output.
module alu_sched #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned RW   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*4-1:0]  req_op,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    input  logic [NREQ*RW-1:0] req_rep,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_id,
    output logic [15:0]        rsp_data,
    output logic               rsp_carry,
    output logic [15:0]        alu_a,
    output logic [15:0]        alu_b,
    output logic [3:0]         alu_sel,
    input  logic [15:0]        alu_out,
    input  logic               alu_carry
`ifdef ALU_SCHED_PERF_EN
    ,
    output logic [15:0]        perf_ops
`endif
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    localparam logic [RW-1:0] RepOne  = RW'(1);
    localparam logic [1:0]    LastIdx = 2'(NREQ - 1);
    localparam logic [2:0]    NreqW   = 3'(NREQ);

    state_e        state;
    logic [1:0]    rr_ptr;
    logic [3:0]    op_r;
    logic [15:0]   acc;
    logic [15:0]   b_r;
    logic [RW-1:0] cnt;
    logic [1:0]    id_r;
    logic          carry_acc;

    // Requester fields padded out to four slots so a 2-bit index always fits exactly.
    logic [3:0]    valid4;
    logic [3:0]    op_arr  [4];
    logic [15:0]   a_arr   [4];
    logic [15:0]   b_arr   [4];
    logic [RW-1:0] rep_arr [4];

    for (genvar g = 0; g < 4; g++) begin : g_unpack
        if (g < NREQ) begin : g_act
            assign valid4[g]  = req_valid[g];
            assign op_arr[g]  = req_op[4*g +: 4];
            assign a_arr[g]   = req_a[16*g +: 16];
            assign b_arr[g]   = req_b[16*g +: 16];
            assign rep_arr[g] = req_rep[RW*g +: RW];
        end else begin : g_pad
            assign valid4[g]  = 1'b0;
            assign op_arr[g]  = '0;
            assign a_arr[g]   = '0;
            assign b_arr[g]   = '0;
            assign rep_arr[g] = '0;
        end
    end

    logic       gnt_found;
    logic [1:0] gnt_idx;
    logic [2:0] scan_sum;
    logic [1:0] gnt_next;
    logic [3:0] ready4;
    logic       accept;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr} + 3'(k);
            if (scan_sum >= NreqW) begin
                scan_sum = scan_sum - NreqW;
            end
            if (!gnt_found && valid4[scan_sum[1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_sum[1:0];
            end
        end
    end

    assign gnt_next = (gnt_idx == LastIdx) ? 2'd0 : gnt_idx + 2'd1;
    assign accept   = (state == StIdle) && gnt_found;

    always_comb begin
        ready4 = 4'b0000;
        if (accept && !reset) begin
            ready4 = 4'b0001 << gnt_idx;
        end
        req_ready = ready4[NREQ-1:0];
    end

    // Outside EXEC the ALU is parked on pass-A so it never sees a stale op.
    always_comb begin
        alu_a   = acc;
        alu_b   = b_r;
        alu_sel = (state == StExec) ? op_r : 4'b1111;
    end

`ifdef ALU_SCHED_PERF_EN
    logic [15:0] perf_cnt;
    assign perf_ops = perf_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StIdle;
            rr_ptr    <= '0;
            op_r      <= '0;
            acc       <= '0;
            b_r       <= '0;
            cnt       <= '0;
            id_r      <= '0;
            carry_acc <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_id    <= '0;
`ifdef ALU_SCHED_PERF_EN
            perf_cnt  <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        op_r      <= op_arr[gnt_idx];
                        acc       <= a_arr[gnt_idx];
                        b_r       <= b_arr[gnt_idx];
                        cnt       <= rep_arr[gnt_idx];
                        id_r      <= gnt_idx;
                        carry_acc <= 1'b0;
                        rr_ptr    <= gnt_next;
                        state     <= StExec;
                    end
                end
                StExec: begin
                    acc       <= alu_out;
                    carry_acc <= carry_acc | alu_carry;
                    if (cnt == '0) begin
                        rsp_data  <= alu_out;
                        rsp_carry <= carry_acc | alu_carry;
                        rsp_id    <= id_r;
                        rsp_valid <= 1'b1;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt - RepOne;
                    end
                end
                StDone: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= StIdle;
`ifdef ALU_SCHED_PERF_EN
                        perf_cnt  <= perf_cnt + 16'd1;
`endif
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
